// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default datapath widths, psum lane packing and
// the accumulator controller state encoding.
package accel_pkg;

  localparam int unsigned DEF_BIT_WIDTH  = 8;
  localparam int unsigned DEF_NUM_KERNEL = 4;
  localparam int unsigned DEF_ACC_WIDTH  = 24;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_PASS_WIDTH = 8;

  // Router psum lanes are double-width products, packed lane k at [W*k +: W].
  localparam int unsigned PSUM_LANE_WIDTH = 2 * DEF_BIT_WIDTH;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/acc_buffer.sv
// Simple dual-port accumulator RAM: one write port, one read port with a
// registered 1-cycle read. Read-during-write to the same address returns old data.
module acc_buffer #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Accumulates router psums over several channel-group passes into acc_buffer,
// then drains the per-pixel sums to the output writer over valid/ready.
module psum_accum_ctrl
  import accel_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int unsigned NUM_KERNEL = DEF_NUM_KERNEL,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned PASS_WIDTH = DEF_PASS_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [ADDR_WIDTH-1:0]             i_cfg_num_pixel,
  input  logic [PASS_WIDTH-1:0]             i_cfg_num_pass,
  output logic                              o_busy,
  output logic                              o_done,
  input  logic [2*BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
  input  logic                              i_psum_vld,
  output logic                              o_psum_rdy,
  output logic [ACC_WIDTH*NUM_KERNEL-1:0]   o_acc_data,
  output logic [ADDR_WIDTH-1:0]             o_acc_addr,
  output logic                              o_acc_vld,
  input  logic                              i_acc_rdy
);

  localparam int unsigned LaneW = 2 * BIT_WIDTH;
  localparam int unsigned DataW = ACC_WIDTH * NUM_KERNEL;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]       num_pixel_q, pixel_cnt_q;
  logic [PASS_WIDTH-1:0]       num_pass_q, pass_cnt_q;

  logic                        s1_vld_q, s1_first_q;
  logic [ADDR_WIDTH-1:0]       s1_addr_q;
  logic [LaneW*NUM_KERNEL-1:0] s1_psum_q;
  logic                        fwd_q;
  logic [DataW-1:0]            fwd_data_q;

  logic                        rd_vld_q;
  logic [ADDR_WIDTH-1:0]       rd_addr_q;
  logic                        out_vld_q;
  logic [DataW-1:0]            out_data_q;
  logic [ADDR_WIDTH-1:0]       out_addr_q;

  logic                        start, accept, last_pixel, accum_fin;
  logic                        out_adv, rd_issue, last_hs;
  logic [ADDR_WIDTH-1:0]       ram_raddr;
  logic [DataW-1:0]            ram_rdata, old_data, sum_data;

  assign start      = (state_q == StIdle) & i_start;
  assign accept     = i_psum_vld & o_psum_rdy;
  assign last_pixel = pixel_cnt_q == (num_pixel_q - ADDR_WIDTH'(1));
  assign accum_fin  = pass_cnt_q == num_pass_q;

  // Drain: the output register advances when empty or consumed; otherwise the
  // pending read address is re-read so the RAM output holds its value.
  assign out_adv   = ~out_vld_q | i_acc_rdy;
  assign rd_issue  = (state_q == StDrain) & out_adv & (pixel_cnt_q != num_pixel_q);
  assign last_hs   = (state_q == StDrain) & out_vld_q & i_acc_rdy &
                     (out_addr_q == (num_pixel_q - ADDR_WIDTH'(1)));
  assign ram_raddr = ((state_q == StDrain) && !out_adv) ? rd_addr_q : pixel_cnt_q;

  // A write retiring while the same pixel is read leaves stale RAM data; bypass it.
  assign old_data = fwd_q ? fwd_data_q : ram_rdata;

  always_comb begin
    sum_data = '0;
    for (int k = 0; k < NUM_KERNEL; k++) begin
      sum_data[k*ACC_WIDTH +: ACC_WIDTH] =
          (s1_first_q ? '0 : old_data[k*ACC_WIDTH +: ACC_WIDTH]) +
          ACC_WIDTH'(s1_psum_q[k*LaneW +: LaneW]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StAccum;
      StAccum: if (accum_fin && !s1_vld_q) state_d = StDrain;
      StDrain: if (last_hs) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy     = state_q != StIdle;
    o_done     = state_q == StDone;
    o_psum_rdy = (state_q == StAccum) & ~accum_fin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_psum_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      s1_vld_q <= accept;
      fwd_q    <= s1_vld_q & accept & (s1_addr_q == pixel_cnt_q);
      if (s1_vld_q) begin
        fwd_data_q <= sum_data;
      end
      if (accept) begin
        s1_addr_q  <= pixel_cnt_q;
        s1_psum_q  <= i_psum;
        s1_first_q <= pass_cnt_q == '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_pixel_q <= '0;
      num_pass_q  <= '0;
      pixel_cnt_q <= '0;
      pass_cnt_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else if (start) begin
      num_pixel_q <= (i_cfg_num_pixel == '0) ? ADDR_WIDTH'(1) : i_cfg_num_pixel;
      num_pass_q  <= (i_cfg_num_pass == '0) ? PASS_WIDTH'(1) : i_cfg_num_pass;
      pixel_cnt_q <= '0;
      pass_cnt_q  <= '0;
      rd_vld_q    <= 1'b0;
      out_vld_q   <= 1'b0;
    end else if (accept) begin
      if (last_pixel) begin
        pixel_cnt_q <= '0;
        pass_cnt_q  <= pass_cnt_q + PASS_WIDTH'(1);
      end else begin
        pixel_cnt_q <= pixel_cnt_q + ADDR_WIDTH'(1);
      end
    end else if ((state_q == StDrain) && out_adv) begin
      if (rd_issue) begin
        pixel_cnt_q <= pixel_cnt_q + ADDR_WIDTH'(1);
        rd_addr_q   <= pixel_cnt_q;
      end
      rd_vld_q  <= rd_issue;
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) begin
        out_data_q <= ram_rdata;
        out_addr_q <= rd_addr_q;
      end
    end
  end

  assign o_acc_vld  = out_vld_q;
  assign o_acc_data = out_data_q;
  assign o_acc_addr = out_addr_q;

  acc_buffer #(
    .DATA_WIDTH(DataW),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_acc_buffer (
    .clk      (clk),
    .wr_en_i  (s1_vld_q),
    .wr_addr_i(s1_addr_q),
    .wr_data_i(sum_data),
    .rd_addr_i(ram_raddr),
    .rd_data_o(ram_rdata)
  );

endmodule
